// File: rtl/tmu2_vdiffops.sv
// TMU2 vertex-difference stage: per-channel sign/magnitude of (b - a) behind a DEPTH-entry output FIFO.
// Optional per-channel equality flags (port diff_zero) are enabled by defining TMU2_VDIFF_ZERO_EN.
module tmu2_vdiffops #(
  parameter int COORD_WIDTH = 18,
  parameter int DR_WIDTH    = 12,
  parameter int NCHAN       = 4,
  parameter int DEPTH       = 2
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  output logic                         busy,
  input  logic                         pipe_stb_i,
  output logic                         pipe_ack_o,
  input  logic [NCHAN*COORD_WIDTH-1:0] a,
  input  logic [NCHAN*COORD_WIDTH-1:0] b,
  input  logic [DR_WIDTH-1:0]          drx,
  input  logic [DR_WIDTH-1:0]          dry,
  output logic                         pipe_stb_o,
  input  logic                         pipe_ack_i,
  output logic [NCHAN*COORD_WIDTH-1:0] a_f,
  output logic [NCHAN-1:0]             diff_positive,
  output logic [NCHAN*COORD_WIDTH-1:0] diff,
`ifdef TMU2_VDIFF_ZERO_EN
  output logic [NCHAN-1:0]             diff_zero,
`endif
  output logic [DR_WIDTH-1:0]          drx_f,
  output logic [DR_WIDTH-1:0]          dry_f
);

  localparam int NW   = NCHAN * COORD_WIDTH;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
`ifdef TMU2_VDIFF_ZERO_EN
  localparam int ZW   = NCHAN;
`else
  localparam int ZW   = 0;
`endif
  // Record layout, LSB first: a, diff_positive, diff, drx, dry, [diff_zero].
  localparam int REC_W    = 2 * NW + NCHAN + 2 * DR_WIDTH + ZW;
  localparam int POS_LSB  = NW;
  localparam int DIFF_LSB = NW + NCHAN;
  localparam int DRX_LSB  = 2 * NW + NCHAN;
  localparam int DRY_LSB  = DRX_LSB + DR_WIDTH;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ZERO_CNT = CNTW'(0);

  // Returns {b > a, |b - a|}; sign-extending one bit keeps the full-range difference exact.
  function automatic logic [COORD_WIDTH:0] sign_mag(
    input logic [COORD_WIDTH-1:0] av,
    input logic [COORD_WIDTH-1:0] bv
  );
    logic signed [COORD_WIDTH:0] ae;
    logic signed [COORD_WIDTH:0] be;
    logic signed [COORD_WIDTH:0] d;
    logic                        gt;
    ae = $signed({av[COORD_WIDTH-1], av});
    be = $signed({bv[COORD_WIDTH-1], bv});
    gt = (be > ae);
    if (gt) begin
      d = be - ae;
    end else begin
      d = ae - be;
    end
    return {gt, d[COORD_WIDTH-1:0]};
  endfunction

  logic [REC_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_next_s;
  logic             ack_r;
  logic             nonempty_r;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [PW-1:0]    head_s;
  logic [REC_W-1:0] head_rec_s;
  logic [REC_W-1:0] wr_rec_s;
  logic [NCHAN-1:0] pos_s;
  logic [NW-1:0]    diff_s;
  logic [NCHAN-1:0] zero_s;

  // Per-channel difference computation on the upstream inputs.
  always_comb begin
    logic [COORD_WIDTH:0] sm;
    pos_s  = {NCHAN{1'b0}};
    diff_s = {NW{1'b0}};
    zero_s = {NCHAN{1'b0}};
    sm     = {(COORD_WIDTH+1){1'b0}};
    for (int k = 0; k < NCHAN; k++) begin
      sm = sign_mag(a[k*COORD_WIDTH +: COORD_WIDTH], b[k*COORD_WIDTH +: COORD_WIDTH]);
      pos_s[k] = sm[COORD_WIDTH];
      diff_s[k*COORD_WIDTH +: COORD_WIDTH] = sm[COORD_WIDTH-1:0];
      zero_s[k] = (a[k*COORD_WIDTH +: COORD_WIDTH] == b[k*COORD_WIDTH +: COORD_WIDTH]);
    end
  end

  // Assemble the record written into the FIFO.
  always_comb begin
`ifdef TMU2_VDIFF_ZERO_EN
    wr_rec_s = {zero_s, dry, drx, diff_s, pos_s, a};
`else
    wr_rec_s = {dry, drx, diff_s, pos_s, a};
`endif
  end

  assign wr_en_s = pipe_stb_i & ack_r;
  assign rd_en_s = (count_r != ZERO_CNT) & pipe_ack_i;

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    case ({wr_en_s, rd_en_s})
      2'b10:   count_next_s = count_r + CNTW'(1);
      2'b01:   count_next_s = count_r - CNTW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // When empty, point at the most recently popped slot so outputs hold the last head.
  always_comb begin
    if (count_r != ZERO_CNT) begin
      head_s = rd_ptr_r;
    end else begin
      head_s = rd_ptr_r - PW'(1);
    end
  end

  assign head_rec_s = mem_r[head_s];

  // FIFO pointers, occupancy and registered handshake flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= ZERO_CNT;
      ack_r      <= 1'b1;
      nonempty_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r    <= count_next_s;
      ack_r      <= (count_next_s != FULL_CNT);
      nonempty_r <= (count_next_s != ZERO_CNT);
    end
  end

  // Record storage; reset clears every slot so outputs read zero afterwards.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {REC_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_rec_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign pipe_ack_o    = ack_r;
  assign pipe_stb_o    = nonempty_r;
  assign busy          = nonempty_r;
  assign a_f           = head_rec_s[NW-1:0];
  assign diff_positive = head_rec_s[POS_LSB +: NCHAN];
  assign diff          = head_rec_s[DIFF_LSB +: NW];
  assign drx_f         = head_rec_s[DRX_LSB +: DR_WIDTH];
  assign dry_f         = head_rec_s[DRY_LSB +: DR_WIDTH];
`ifdef TMU2_VDIFF_ZERO_EN
  assign diff_zero     = head_rec_s[DRY_LSB + DR_WIDTH +: NCHAN];
`endif

endmodule

// File: tb/tb_tmu2_vdiffops.sv
// Self-checking bench for tmu2_vdiffops: directed vector table, stall/reset sequences and random traffic
// compared against a queue-based reference model.
module tb_tmu2_vdiffops;
  localparam int CW  = 18;
  localparam int DRW = 12;
  localparam int N   = 4;
  localparam int D   = 2;
  localparam int NW  = N * CW;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           busy;
  logic           pipe_stb_i;
  logic           pipe_ack_o;
  logic [NW-1:0]  a;
  logic [NW-1:0]  b;
  logic [DRW-1:0] drx;
  logic [DRW-1:0] dry;
  logic           pipe_stb_o;
  logic           pipe_ack_i;
  logic [NW-1:0]  a_f;
  logic [N-1:0]   diff_positive;
  logic [NW-1:0]  diff;
  logic [N-1:0]   diff_zero;
  logic [DRW-1:0] drx_f;
  logic [DRW-1:0] dry_f;

  tmu2_vdiffops #(.COORD_WIDTH(CW), .DR_WIDTH(DRW), .NCHAN(N), .DEPTH(D)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .busy(busy),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
    .a(a), .b(b), .drx(drx), .dry(dry),
    .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
    .a_f(a_f), .diff_positive(diff_positive), .diff(diff),
`ifdef TMU2_VDIFF_ZERO_EN
    .diff_zero(diff_zero),
`endif
    .drx_f(drx_f), .dry_f(dry_f)
  );

`ifndef TMU2_VDIFF_ZERO_EN
  assign diff_zero = '0;
`endif

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DRW-1:0] dry;
    logic [DRW-1:0] drx;
    logic [N-1:0]   zero;
    logic [NW-1:0]  diff;
    logic [N-1:0]   pos;
    logic [NW-1:0]  a;
  } rec_t;

  typedef struct {
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic [N-1:0]  pos;
    logic [NW-1:0] diff;
  } vec_t;

  rec_t q[$];
  rec_t last_head;
  rec_t h;
  bit   exp_ack;
  bit   last_acc;
  bit   pop;
  int   vectors;
  int   miscompares;
  vec_t tbl[4];

  // Reference: plain integer arithmetic on the signed channel values.
  function automatic rec_t model(input logic [NW-1:0] av, input logic [NW-1:0] bv,
                                 input logic [DRW-1:0] x, input logic [DRW-1:0] y);
    rec_t r;
    int   ai;
    int   bi;
    int   d;
    r = '0;
    r.a = av;
    r.drx = x;
    r.dry = y;
    for (int k = 0; k < N; k++) begin
      ai = $signed(av[k*CW +: CW]);
      bi = $signed(bv[k*CW +: CW]);
      d = bi - ai;
      r.pos[k] = (d > 0);
      r.zero[k] = (d == 0);
      r.diff[k*CW +: CW] = CW'((d < 0) ? -d : d);
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
    logic [NW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(v0);
    r[1*CW +: CW] = CW'(v1);
    r[2*CW +: CW] = CW'(v2);
    r[3*CW +: CW] = CW'(v3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, then compare every output at the falling edge.
  task automatic step();
    @(posedge sys_clk);
    last_acc = 1'b0;
    if (sys_rst) begin
      q.delete();
      last_head = '0;
    end else begin
      last_acc = pipe_stb_i && exp_ack;
      pop = (q.size() != 0) && pipe_ack_i;
      if (pop) last_head = q.pop_front();
      if (last_acc) q.push_back(model(a, b, drx, dry));
    end
    exp_ack = (q.size() != D);
    @(negedge sys_clk);
    h = (q.size() != 0) ? q[0] : last_head;
    chk("stb_o", NW'(pipe_stb_o), NW'(q.size() != 0));
    chk("busy", NW'(busy), NW'(q.size() != 0));
    chk("ack_o", NW'(pipe_ack_o), NW'(exp_ack));
    chk("a_f", a_f, h.a);
    chk("diff_positive", NW'(diff_positive), NW'(h.pos));
    chk("diff", diff, h.diff);
    chk("drx_f", NW'(drx_f), NW'(h.drx));
    chk("dry_f", NW'(dry_f), NW'(h.dry));
`ifdef TMU2_VDIFF_ZERO_EN
    chk("diff_zero", NW'(diff_zero), NW'(h.zero));
`endif
  endtask

  function automatic logic [CW-1:0] rnd_coord();
    case ($urandom_range(0, 3))
      0:       return 18'h20000;
      1:       return 18'h1FFFF;
      2:       return CW'($urandom);
      default: return CW'(int'($urandom_range(0, 20)) - 10);
    endcase
  endfunction

  task automatic randomize_inputs();
    logic [CW-1:0] c;
    for (int k = 0; k < N; k++) begin
      c = rnd_coord();
      a[k*CW +: CW] = c;
      b[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? c : rnd_coord();
    end
    drx = DRW'($urandom);
    dry = DRW'($urandom);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_ack = 1'b1;
    last_head = '0;
    sys_rst = 1'b1;
    pipe_stb_i = 1'b0;
    pipe_ack_i = 1'b0;
    a = '0;
    b = '0;
    drx = '0;
    dry = '0;

    tbl[0] = '{pk(10, -5, 0, 100), pk(3, 7, 0, -100), 4'b0010, pk(7, 12, 0, 200)};
    tbl[1] = '{pk(-131072, 131071, 5, -1), pk(131071, -131072, 5, 0), 4'b1001,
               pk(262143, 262143, 0, 1)};
    tbl[2] = '{pk(-7, 7, -3, 3), pk(-8, 8, -3, -3), 4'b0010, pk(1, 1, 0, 6)};
    tbl[3] = '{pk(4, 4, 4, 4), pk(4, 5, 4, 5), 4'b1010, pk(0, 1, 0, 1)};

    // Reset state.
    step();
    step();
    chk("rst_stb_o", NW'(pipe_stb_o), NW'(1'b0));
    chk("rst_ack_o", NW'(pipe_ack_o), NW'(1'b1));
    chk("rst_diff", diff, '0);
    sys_rst = 1'b0;
    step();

    // Directed table: each record visible one cycle after its accept.
    pipe_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = tbl[i].a;
      b = tbl[i].b;
      drx = DRW'(i * 37 - 50);
      dry = DRW'(-i * 11);
      pipe_stb_i = 1'b1;
      step();
      pipe_stb_i = 1'b0;
      chk("tbl_stb_o", NW'(pipe_stb_o), NW'(1'b1));
      chk("tbl_pos", NW'(diff_positive), NW'(tbl[i].pos));
      chk("tbl_diff", diff, tbl[i].diff);
      chk("tbl_a_f", a_f, tbl[i].a);
      step();
    end

    // Stall: two accepts fill the FIFO, third waits until the first pop.
    pipe_ack_i = 1'b0;
    pipe_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      step();
      if (i == 0) chk("stall_ack_1", NW'(pipe_ack_o), NW'(1'b1));
      else chk("stall_ack_full", NW'(pipe_ack_o), NW'(1'b0));
    end
    pipe_ack_i = 1'b1;
    step();
    chk("stall_ack_rise", NW'(pipe_ack_o), NW'(1'b1));
    step();
    chk("stall_third_acc", NW'(last_acc), NW'(1'b1));
    pipe_stb_i = 1'b0;
    step();
    step();
    step();

    // Back-to-back: one record per cycle, never fills.
    pipe_ack_i = 1'b1;
    pipe_stb_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      randomize_inputs();
      step();
      chk("b2b_ack", NW'(pipe_ack_o), NW'(1'b1));
      chk("b2b_stb_o", NW'(pipe_stb_o), NW'(1'b1));
    end
    pipe_stb_i = 1'b0;
    step();
    step();

    // Reset with the FIFO full.
    pipe_ack_i = 1'b0;
    pipe_stb_i = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    chk("full_ack", NW'(pipe_ack_o), NW'(1'b0));
    pipe_stb_i = 1'b0;
    sys_rst = 1'b1;
    step();
    chk("rstfull_stb_o", NW'(pipe_stb_o), NW'(1'b0));
    chk("rstfull_ack_o", NW'(pipe_ack_o), NW'(1'b1));
    chk("rstfull_a_f", a_f, '0);
    sys_rst = 1'b0;
    pipe_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstfull_no_stale", NW'(pipe_stb_o), NW'(1'b0));
    end

    // Random traffic; inputs held while strobed and not yet acknowledged.
    for (int i = 0; i < 500; i++) begin
      if (!(pipe_stb_i && !last_acc)) begin
        pipe_stb_i = ($urandom_range(0, 9) < 7);
        randomize_inputs();
      end
      pipe_ack_i = ($urandom_range(0, 9) < 6);
      sys_rst = ($urandom_range(0, 199) == 0);
      step();
      sys_rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tmu2_vdiffops.md
# tmu2_vdiffops

Parametrised vertex-difference stage for the TMU2 texture-mapping pipeline. For each of NCHAN coordinate channels it computes the sign and absolute magnitude of the difference (b − a) and passes the base coordinates and destination-rectangle deltas through. An internal DEPTH-entry output FIFO decouples upstream acknowledge from downstream acknowledge, so the block absorbs downstream stalls without a combinational ack path.

## Interface
Parameters:
- COORD_WIDTH, 18, signed coordinate width
- DR_WIDTH, 12, signed width of drx/dry
- NCHAN, 4, number of difference channels
- DEPTH, 2, output FIFO entries; power of two, ≥ 2

Ports (one clock `sys_clk`; reset `sys_rst` is synchronous, active-high):
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- busy  out  1  FIFO non-empty
- pipe_stb_i  in  1  upstream strobe
- pipe_ack_o  out  1  upstream acknowledge, registered: 1 when FIFO not full
- a  in  NCHAN*COORD_WIDTH  packed signed base coordinates, channel k at [k*COORD_WIDTH +: COORD_WIDTH]
- b  in  NCHAN*COORD_WIDTH  packed signed target coordinates
- drx, dry  in  DR_WIDTH each  signed destination deltas
- pipe_stb_o  out  1  output valid (FIFO non-empty)
- pipe_ack_i  in  1  downstream acknowledge
- a_f  out  NCHAN*COORD_WIDTH  forwarded a
- diff_positive  out  NCHAN  1 when b_k > a_k
- diff  out  NCHAN*COORD_WIDTH  unsigned |b_k − a_k|
- diff_zero  out  NCHAN  present only with TMU2_VDIFF_ZERO_EN
- drx_f, dry_f  out  DR_WIDTH each  forwarded deltas

## Operation
- Upstream transfer: pipe_stb_i & pipe_ack_o. Downstream transfer: pipe_stb_o & pipe_ack_i.
- On upstream transfer, per channel: if b_k > a_k (signed compare), diff_positive=1, diff=b_k−a_k; otherwise diff_positive=0, diff=a_k−b_k. Subtraction performed at COORD_WIDTH+1 bits; result always fits COORD_WIDTH unsigned bits (max 2^COORD_WIDTH − 1); no truncation.
- Equal inputs: diff_positive=0, diff=0.
- Computed record {a, diff_positive, diff, [diff_zero], drx, dry} written at write pointer; head entry drives all data outputs.
- State: write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH), occupancy count 0..DEPTH.
- Write only: count+1. Read only: count−1. Both in same cycle: count unchanged, both pointers advance.
- pipe_ack_o = (count != DEPTH), registered from next-count; pipe_stb_o = busy = (count != 0).
- Full and pipe_ack_i high in same cycle: head pops, pipe_ack_o rises next cycle; no same-cycle accept.
- Empty: pipe_ack_i ignored; data outputs hold last head contents.
- Upstream must hold inputs stable while pipe_stb_i high and not acknowledged.

## Timing
- Reset (any time, including mid-transfer): pointers=0, count=0, pipe_stb_o=0, busy=0, pipe_ack_o=1, storage cleared so all data outputs read 0. In-flight entries discarded.
- Latency: accept at edge N → pipe_stb_o=1 and valid data after edge N (visible cycle N+1).
- Throughput: one record per cycle sustained when pipe_ack_i held high.
- After DEPTH accepts with pipe_ack_i low, pipe_ack_o=0 the following cycle.

## Configuration
- TMU2_VDIFF_ZERO_EN defined: extra NCHAN-bit FIFO field and port diff_zero; diff_zero[k]=1 iff a_k == b_k, registered with the record.
- Undefined: no diff_zero port or storage; all other behaviour identical.

## Test plan
- Reset then single record, NCHAN=4, a={10,−5,0,100}, b={3,7,0,−100}: one cycle later pipe_stb_o=1, diff_positive={0,1,0,0}, diff={7,12,0,200}.
- Extremes, COORD_WIDTH=18: a=−131072, b=131071 → diff_positive=1, diff=262143; swapped → diff_positive=0, diff=262143.
- Stall: pipe_ack_i=0, stream 3 records with DEPTH=2 → first two accepted, pipe_ack_o=0 after second; raise pipe_ack_i → outputs in order, third accepted one cycle after first pop.
- Back-to-back with pipe_ack_i=1 for 16 records: one output per cycle, count never exceeds 1, order preserved across pointer wrap.
- Assert sys_rst with FIFO full: next cycle pipe_stb_o=0, pipe_ack_o=1, outputs 0; no stale record emitted afterwards.
- With TMU2_VDIFF_ZERO_EN: a={4,4,…}, b={4,5,…} → diff_zero={1,0,…}; build without macro compiles without the port.
